// File: rtl/kara16_combine_seq.sv
// kara16_combine_seq: sequential Karatsuba recombination stage.
// Computes p = (z2 << 16) + ((z1 - z2 - z0) << MID_SHIFT) + z0 by
// reusing one 32-bit adder (scb_rca32) across three cycles.
// Optional macro KARA_OVF_CHECK_EN adds an err output. The flag is set when
// the middle term goes negative or the final add carries out.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its data stable while valid is high and ready is low.
// in_ready is high only in IDLE. p and out_valid stay constant until
// out_ready is seen.

// 32-bit adder: a 16-bit ripple low half, and a carry-select high half with
// a binary-to-excess-one (+1) path chosen by the low-half carry.
module scb_rca32 (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);
   logic [16:0] lo_sum;
   logic [16:0] hi_sum0;
   logic [16:0] hi_sum1;

   // Low half ripple, high half precomputed for carry-in 0 and 1
   always_comb begin
      lo_sum  = {1'b0, x[15:0]} + {1'b0, y[15:0]} + {16'b0, cin};
      hi_sum0 = {1'b0, x[31:16]} + {1'b0, y[31:16]};
      hi_sum1 = hi_sum0 + 17'd1;
      s[15:0] = lo_sum[15:0];
      if (lo_sum[16]) begin
         s[31:16] = hi_sum1[15:0];
         cout     = hi_sum1[16];
      end else begin
         s[31:16] = hi_sum0[15:0];
         cout     = hi_sum0[16];
      end
   end
endmodule

module kara16_combine_seq #(
   parameter int unsigned MID_SHIFT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] z0,
   input  logic [17:0] z1,
   input  logic [15:0] z2,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef KARA_OVF_CHECK_EN
   output logic        err,
`endif
   output logic [31:0] p
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SUB0 = 3'd1,
      SUB2 = 3'd2,
      MID  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [15:0] z0_q, z0_d;
   logic [17:0] z1_q, z1_d;
   logic [15:0] z2_q, z2_d;
   logic [31:0] p_q, p_d;
   logic        out_valid_q, out_valid_d;

   logic [31:0] add_x;
   logic [31:0] add_y;
   logic        add_cin;
   logic [31:0] add_s;
`ifdef KARA_OVF_CHECK_EN
   logic        add_cout;
   logic        err_q, err_d;
`else
   logic        add_cout_unused;
`endif

   scb_rca32 u_add (
      .x    (add_x),
      .y    (add_y),
      .cin  (add_cin),
      .s    (add_s),
`ifdef KARA_OVF_CHECK_EN
      .cout (add_cout)
`else
      .cout (add_cout_unused)
`endif
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign p         = p_q;
`ifdef KARA_OVF_CHECK_EN
   assign err       = out_valid_q & err_q;
`endif

   // Next-state, operand steering for the shared adder, and output staging
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      z0_d        = z0_q;
      z1_d        = z1_q;
      z2_d        = z2_q;
      p_d         = p_q;
      out_valid_d = out_valid_q;
      add_x       = 32'd0;
      add_y       = 32'd0;
      add_cin     = 1'b0;
`ifdef KARA_OVF_CHECK_EN
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               z0_d    = z0;
               z1_d    = z1;
               z2_d    = z2;
               state_d = SUB0;
`ifdef KARA_OVF_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         SUB0: begin
            // acc = z1 - z0 (two's complement subtract)
            add_x   = {14'b0, z1_q};
            add_y   = ~{16'b0, z0_q};
            add_cin = 1'b1;
            acc_d   = add_s;
            state_d = SUB2;
`ifdef KARA_OVF_CHECK_EN
            if (!add_cout) err_d = 1'b1;
`endif
         end
         SUB2: begin
            // acc = z1 - z0 - z2
            add_x   = acc_q;
            add_y   = ~{16'b0, z2_q};
            add_cin = 1'b1;
            acc_d   = add_s;
            state_d = MID;
`ifdef KARA_OVF_CHECK_EN
            if (!add_cout) err_d = 1'b1;
`endif
         end
         MID: begin
            // {z2,z0} already holds z2<<16 + z0; add the shifted middle term
            add_x   = {z2_q, z0_q};
            add_y   = acc_q << MID_SHIFT;
            add_cin = 1'b0;
            acc_d   = add_s;
            state_d = DONE;
`ifdef KARA_OVF_CHECK_EN
            if (add_cout) err_d = 1'b1;
`endif
         end
         DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               p_d         = acc_q;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= 32'd0;
         z0_q        <= 16'd0;
         z1_q        <= 18'd0;
         z2_q        <= 16'd0;
         p_q         <= 32'd0;
         out_valid_q <= 1'b0;
`ifdef KARA_OVF_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         z0_q        <= z0_d;
         z1_q        <= z1_d;
         z2_q        <= z2_d;
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
`ifdef KARA_OVF_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_kara16_combine_seq.sv
// Testbench for kara16_combine_seq: table of directed vectors plus
// hand-written back-pressure and mid-operation reset sequences.
module tb_kara16_combine_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z0;
  logic [17:0] z1;
  logic [15:0] z2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
`ifdef KARA_OVF_CHECK_EN
  logic        err;
`endif

  int total;
  int bad;

  typedef struct {
    logic [15:0] z0;
    logic [17:0] z1;
    logic [15:0] z2;
    logic [31:0] p;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[7];

  kara16_combine_seq #(.MID_SHIFT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef KARA_OVF_CHECK_EN
    .err       (err),
`endif
    .p         (p)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits for out_valid, counting edges; gives up after 20
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  // driver: present one transaction, return after the accept edge
  task automatic drive(input logic [15:0] a0, input logic [17:0] a1, input logic [15:0] a2);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    z0 = a0; z1 = a1; z2 = a2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    out_ready = 1'b1;
    drive(v.z0, v.z1, v.z2);
    wait_out(cnt);
    check({v.name, "_latency"}, cnt, 32'd4);
    check({v.name, "_p"}, p, v.p);
`ifdef KARA_OVF_CHECK_EN
    check({v.name, "_err"}, {31'b0, err}, {31'b0, v.err});
`endif
    tick();
    check({v.name, "_pulse_end"}, {31'b0, out_valid}, 32'd0);
    check({v.name, "_idle_again"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int cnt;
    int seen;
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    z0 = '0; z1 = '0; z2 = '0;

    // z0, z1, z2, p, err
    vecs[0] = '{16'h1860, 18'h03854, 16'h060C, 32'h06260060, 1'b0, "v1234x5678"};
    vecs[1] = '{16'hFE01, 18'h3F804, 16'hFE01, 32'hFFFE0001, 1'b0, "vffffxffff"};
    vecs[2] = '{16'h0000, 18'h00000, 16'h0000, 32'h00000000, 1'b0, "vzero"};
    vecs[3] = '{16'h0000, 18'h000FF, 16'h0000, 32'h0000FF00, 1'b0, "v00ffx0100"};
    vecs[4] = '{16'h00CD, 18'h00178, 16'h0000, 32'h0000ABCD, 1'b0, "vabcdx0001"};
    vecs[5] = '{16'h0001, 18'h00000, 16'h0000, 32'hFFFFFF01, 1'b1, "vnegmid"};
    vecs[6] = '{16'h1860, 18'h03854, 16'h060C, 32'h06260060, 1'b0, "vafter_err"};

    // 1: reset held 3 cycles
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_p", p, 32'd0);
`ifdef KARA_OVF_CHECK_EN
    check("rst_err", {31'b0, err}, 32'd0);
`endif

    // 2,3,6 and extras: table-driven
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // 4: back-pressure with new data waiting
    out_ready = 1'b0;
    drive(16'h1860, 18'h03854, 16'h060C);
    wait_out(cnt);
    check("bp_latency", cnt, 32'd4);
    z0 = 16'hFE01; z1 = 18'h3F804; z2 = 16'hFE01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_p", p, 32'h06260060);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_handshake_valid", {31'b0, out_valid}, 32'd0);
    check("bp_handshake_idle", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_new_accepted", {31'b0, in_ready}, 32'd0);
    wait_out(cnt);
    check("bp_new_latency", cnt, 32'd4);
    check("bp_new_p", p, 32'hFFFE0001);
    tick();
    check("bp_new_pulse_end", {31'b0, out_valid}, 32'd0);

    // 5: reset while in SUB2
    drive(16'h1860, 18'h03854, 16'h060C);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_p", p, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 32'd0);
    check("midrst_still_idle", {31'b0, in_ready}, 32'd1);

    // recovery after mid-operation reset
    run_vec(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
